// File: rtl/instr_ram_loader.sv
// instr_ram_loader: packs four 16-bit program words into one 64-bit
// instruction ({w0,w1,w2,w3}, w0 in [63:48]) and writes consecutive
// instruction RAM slots from address 0 until an EOF opcode is written.
// Optional build macro LOADER_CHECKSUM_EN adds a running word checksum that
// is compared against expected_checksum when the EOF instruction completes.
module instr_ram_loader #(
   parameter int          ADDR_W     = 16,
   parameter int          DEPTH      = 256,
   parameter logic [15:0] EOF_OPCODE = 16'h0000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [15:0]       word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic [ADDR_W-1:0] ram_address,
   output logic [63:0]       ram_data,
   output logic              ram_wren,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] instr_count
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [15:0]       checksum,
   input  logic [15:0]       expected_checksum
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_WRITE   = 3'd2,
      S_DONE    = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   // One extra address bit so that "address == DEPTH" is representable and
   // the overflow check can never be defeated by a silent wrap.
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

   state_t            r_state;
   logic [ADDR_W:0]   r_addr;
   logic [ADDR_W-1:0] r_count;
   logic [1:0]        r_idx;
   logic [63:0]       r_data;
   logic [ADDR_W-1:0] r_ram_address;
   logic              r_ram_wren;
   logic              r_word_ready;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic [15:0]       r_checksum;

   logic              w_accept;
   logic              w_in_range;
   logic              w_sum_ok;

   assign w_accept   = word_valid && r_word_ready;
   assign w_in_range = (r_addr < LP_DEPTH);

`ifdef LOADER_CHECKSUM_EN
   assign w_sum_ok = (r_checksum == expected_checksum);
   assign checksum = r_checksum;
`else
   assign w_sum_ok = 1'b1;
`endif

   assign word_ready  = r_word_ready;
   assign ram_address = r_ram_address;
   assign ram_data    = r_data;
   assign ram_wren    = r_ram_wren;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;
   assign instr_count = r_count;

   // Loader FSM: word collection, RAM write strobe and status flags, all registered.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_addr        <= '0;
         r_count       <= '0;
         r_idx         <= 2'd0;
         r_data        <= 64'h0;
         r_ram_address <= '0;
         r_ram_wren    <= 1'b0;
         r_word_ready  <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
         r_checksum    <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               r_ram_wren <= 1'b0;
               if (start) begin
                  // Fresh load: any partial instruction from before is dropped.
                  r_state      <= S_COLLECT;
                  r_addr       <= '0;
                  r_count      <= '0;
                  r_idx        <= 2'd0;
                  r_data       <= 64'h0;
                  r_checksum   <= 16'h0000;
                  r_done       <= 1'b0;
                  r_error      <= 1'b0;
                  r_busy       <= 1'b1;
                  r_word_ready <= 1'b1;
               end else begin
                  r_state <= r_state;
               end
            end

            S_COLLECT: begin
               r_ram_wren <= 1'b0;
               if (w_accept) begin
                  case (r_idx)
                     2'd0:    r_data[63:48] <= word_in;
                     2'd1:    r_data[47:32] <= word_in;
                     2'd2:    r_data[31:16] <= word_in;
                     2'd3:    r_data[15:0]  <= word_in;
                     default: r_data        <= r_data;
                  endcase
                  r_checksum <= r_checksum + word_in;
                  r_idx      <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     // Strobe is raised in the WRITE cycle only when a slot remains.
                     r_state       <= S_WRITE;
                     r_word_ready  <= 1'b0;
                     r_ram_address <= r_addr[ADDR_W-1:0];
                     r_ram_wren    <= w_in_range;
                  end else begin
                     r_state <= S_COLLECT;
                  end
               end else begin
                  r_state <= S_COLLECT;
               end
            end

            S_WRITE: begin
               r_ram_wren <= 1'b0;
               if (w_in_range) begin
                  r_addr  <= r_addr + (ADDR_W + 1)'(1);
                  r_count <= r_count + ADDR_W'(1);
                  if (r_data[63:48] == EOF_OPCODE) begin
                     r_busy <= 1'b0;
                     if (w_sum_ok) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_ERROR;
                        r_error <= 1'b1;
                     end
                  end else begin
                     r_state      <= S_COLLECT;
                     r_word_ready <= 1'b1;
                  end
               end else begin
                  // Overflow: RAM is full, nothing written.
                  r_state <= S_ERROR;
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state      <= S_IDLE;
               r_ram_wren   <= 1'b0;
               r_word_ready <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_ram_loader.sv
// Directed bench for instr_ram_loader, built with a 4-slot RAM so overflow
// is reachable quickly. Define LOADER_CHECKSUM_EN to exercise the checksum.
module tb_instr_ram_loader;

   localparam int ADDR_W = 16;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [15:0]       word_in = 16'h0000;
   logic              word_valid = 1'b0;
   logic              word_ready;
   logic [ADDR_W-1:0] ram_address;
   logic [63:0]       ram_data;
   logic              ram_wren;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W-1:0] instr_count;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]       checksum;
   logic [15:0]       expected_checksum = 16'h0000;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Write log filled by the monitor, read by the directed sequence.
   logic [ADDR_W-1:0] wr_addr [0:63];
   logic [63:0]       wr_data [0:63];
   int                wr_n = 0;
   int                run = 0;
   int                max_run = 0;
   bit                ready_in_wr = 1'b0;
   int                base = 0;

   instr_ram_loader #(.ADDR_W(ADDR_W), .DEPTH(4), .EOF_OPCODE(16'h0000)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .word_in     (word_in),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .instr_count (instr_count)
`ifdef LOADER_CHECKSUM_EN
      ,
      .checksum          (checksum),
      .expected_checksum (expected_checksum)
`endif
   );

   always #5 clock = ~clock;

   // Monitor: log every RAM write, track strobe width and ready overlap.
   always @(negedge clock) begin
      if (ram_wren) begin
         if (wr_n < 64) begin
            wr_addr[wr_n] = ram_address;
            wr_data[wr_n] = ram_data;
         end
         wr_n = wr_n + 1;
         run = run + 1;
         if (run > max_run) max_run = run;
         if (word_ready) ready_in_wr = 1'b1;
      end else begin
         run = 0;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [15:0] w, input bit gap);
      int n = 0;
      word_in = w;
      word_valid = 1'b1;
      while (!word_ready && n < 20) begin
         tick();
         n++;
      end
      check("ready_wait", {63'd0, (n < 20)}, 64'd1);
      tick();
      word_valid = 1'b0;
      if (gap) tick();
   endtask

   task automatic send_instr(input logic [63:0] ins, input bit gap);
      logic [63:0] v;
      v = ins;
      send_word(v[63:48], gap);
      send_word(v[47:32], gap);
      send_word(v[31:16], gap);
      send_word(v[15:0], gap);
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || error) && n < 50) begin
         tick();
         n++;
      end
      check("end_wait", {63'd0, (n < 50)}, 64'd1);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      base = wr_n;
   endtask

   initial begin
      // Reset state
      reset_n = 1'b0;
      tick();
      tick();
      check("rst_ready", word_ready, 64'd0);
      check("rst_wren", ram_wren, 64'd0);
      check("rst_busy", busy, 64'd0);
      check("rst_done", done, 64'd0);
      check("rst_error", error, 64'd0);
      check("rst_count", instr_count, 64'd0);
      check("rst_data", ram_data, 64'd0);
      check("rst_addr", ram_address, 64'd0);
      reset_n = 1'b1;
      tick();

      // Gapless load: one instruction then EOF
`ifdef LOADER_CHECKSUM_EN
      expected_checksum = 16'h000A;
`endif
      do_start();
      check("start_busy", busy, 64'd1);
      check("start_ready", word_ready, 64'd1);
      send_instr(64'h0003_0005_0002_0000, 1'b0);
      send_instr(64'h0000_0000_0000_0000, 1'b0);
      wait_end();
      check("t1_nwr", wr_n - base, 64'd2);
      check("t1_a0", wr_addr[base], 64'd0);
      check("t1_d0", wr_data[base], 64'h0003_0005_0002_0000);
      check("t1_a1", wr_addr[base+1], 64'd1);
      check("t1_d1", wr_data[base+1], 64'h0);
      check("t1_done", done, 64'd1);
      check("t1_error", error, 64'd0);
      check("t1_count", instr_count, 64'd2);
      check("t1_busy", busy, 64'd0);
      check("t1_ready", word_ready, 64'd0);

      // Same load with valid toggling every other cycle
      do_start();
      check("t2_count_clr", instr_count, 64'd0);
      check("t2_done_clr", done, 64'd0);
      send_instr(64'h0003_0005_0002_0000, 1'b1);
      send_instr(64'h0000_0000_0000_0000, 1'b1);
      wait_end();
      check("t2_nwr", wr_n - base, 64'd2);
      check("t2_d0", wr_data[base], 64'h0003_0005_0002_0000);
      check("t2_a1", wr_addr[base+1], 64'd1);
      check("t2_d1", wr_data[base+1], 64'h0);
      check("t2_done", done, 64'd1);
      check("pulse_width", max_run, 64'd1);
      check("ready_in_wr", ready_in_wr, 64'd0);

      // Overflow with 4 slots: five non-EOF instructions
      do_start();
      for (int i = 0; i < 5; i++) begin
         send_instr({16'h0010 + 16'(i), 16'h1000 + 16'(i), 16'h2000, 16'h3000}, 1'b0);
      end
      wait_end();
      check("t3_nwr", wr_n - base, 64'd4);
      check("t3_a0", wr_addr[base], 64'd0);
      check("t3_a3", wr_addr[base+3], 64'd3);
      check("t3_d3", wr_data[base+3], 64'h0013_1003_2000_3000);
      check("t3_error", error, 64'd1);
      check("t3_done", done, 64'd0);
      check("t3_count", instr_count, 64'd4);
      check("t3_busy", busy, 64'd0);
      check("t3_ready", word_ready, 64'd0);

      // Reset in the middle of an instruction
      do_start();
      send_word(16'h1111, 1'b0);
      send_word(16'h2222, 1'b0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("t4_rst_data", ram_data, 64'd0);
      check("t4_rst_busy", busy, 64'd0);
      check("t4_rst_error", error, 64'd0);
`ifdef LOADER_CHECKSUM_EN
      expected_checksum = 16'h0000;
`endif
      do_start();
      send_instr(64'h0000_0000_0000_0000, 1'b0);
      wait_end();
      check("t4_nwr", wr_n - base, 64'd1);
      check("t4_a0", wr_addr[base], 64'd0);
      check("t4_d0", wr_data[base], 64'h0);
      check("t4_done", done, 64'd1);
      check("t4_count", instr_count, 64'd1);

      // start pulse during COLLECT is ignored
`ifdef LOADER_CHECKSUM_EN
      expected_checksum = 16'h000A;
`endif
      do_start();
      send_word(16'h0001, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      send_word(16'h0002, 1'b0);
      send_word(16'h0003, 1'b0);
      send_word(16'h0004, 1'b0);
      send_instr(64'h0000_0000_0000_0000, 1'b0);
      wait_end();
      check("t5_nwr", wr_n - base, 64'd2);
      check("t5_a0", wr_addr[base], 64'd0);
      check("t5_d0", wr_data[base], 64'h0001_0002_0003_0004);
      check("t5_a1", wr_addr[base+1], 64'd1);
      check("t5_done", done, 64'd1);
      check("t5_count", instr_count, 64'd2);

`ifdef LOADER_CHECKSUM_EN
      // Checksum mismatch: EOF still written, ends in ERROR
      expected_checksum = 16'h0013;
      do_start();
      send_instr(64'h0003_0005_0002_0000, 1'b0);
      send_instr(64'h0000_0008_0000_0000, 1'b0);
      wait_end();
      check("cs_sum", checksum, 64'h0012);
      check("cs_bad_nwr", wr_n - base, 64'd2);
      check("cs_bad_d1", wr_data[base+1], 64'h0000_0008_0000_0000);
      check("cs_bad_error", error, 64'd1);
      check("cs_bad_done", done, 64'd0);

      // Checksum match
      expected_checksum = 16'h0012;
      do_start();
      check("cs_clr", checksum, 64'h0);
      send_instr(64'h0003_0005_0002_0000, 1'b0);
      send_instr(64'h0000_0008_0000_0000, 1'b0);
      wait_end();
      check("cs_ok_done", done, 64'd1);
      check("cs_ok_error", error, 64'd0);
`endif

      check("final_pulse_width", max_run, 64'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
